// File: rtl/ascon_blk_fifo_pkg.sv
// ---------------------------------------------------------------------------
// ascon_buf_pkg
// Shared types and default geometry for the ASCON block FIFO.
//   BUS_W_DFLT / BLK_W_DFLT : default bus word and rate block widths
//   WPB                     : bus words per rate block (default geometry)
//   BYTES_PER_BLK           : bytes per rate block (default geometry)
//   blk_entry_t             : queued block {block data, byte length, last}
//   buf_state_t             : packer FSM states (FILL accepts words, PAD
//                             inserts the zero-length final block)
// The top module re-derives the geometry from its own parameters; the
// package values describe the default 32-bit bus / 64-bit rate build.
// ---------------------------------------------------------------------------
package ascon_buf_pkg;

    localparam int BUS_W_DFLT    = 32;
    localparam int BLK_W_DFLT    = 64;
    localparam int WPB           = BLK_W_DFLT / BUS_W_DFLT;
    localparam int BYTES_PER_BLK = BLK_W_DFLT / 8;
    localparam int LEN_W_DFLT    = $clog2(BYTES_PER_BLK) + 1;

    typedef struct packed {
        logic [BLK_W_DFLT-1:0] block;
        logic [LEN_W_DFLT-1:0] len;
        logic                  last;
    } blk_entry_t;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        PAD  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/ascon_blk_fifo_store.sv
// ---------------------------------------------------------------------------
// ascon_blk_store
// DEPTH-entry register FIFO of block entries.
//   clk, nRST   : clock, asynchronous active-low reset
//   clear       : synchronous flush (pointers and count to zero)
//   i_push      : write i_data at the tail (ignored when full)
//   i_pop       : drop the head entry (ignored when empty)
//   o_head      : head entry, all-zero while empty
//   o_empty     : no entries queued
//   o_full      : DEPTH entries queued
//   o_count     : number of queued entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module ascon_blk_store
    import ascon_buf_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = blk_entry_t
) (
    input  logic                     clk,
    input  logic                     nRST,
    input  logic                     clear,
    input  logic                     i_push,
    input  entry_t                   i_data,
    input  logic                     i_pop,
    output entry_t                   o_head,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign o_empty   = (r_count == CNT_W'(0));
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_count   = r_count;
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // Head entry is forced to zero while the queue is empty.
    always_comb begin
        o_head = '0;
        if (!o_empty) begin
            o_head = r_mem[r_rd_ptr];
        end else begin
            o_head = '0;
        end
    end

    // Entry storage: written at the tail on an accepted push.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end

    // Pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_wr_ptr <= PTR_W'(0);
            r_rd_ptr <= PTR_W'(0);
            r_count  <= CNT_W'(0);
        end else if (clear) begin
            r_wr_ptr <= PTR_W'(0);
            r_rd_ptr <= PTR_W'(0);
            r_count  <= CNT_W'(0);
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ascon_blk_fifo.sv
// ---------------------------------------------------------------------------
// ascon_blk_fifo
// Packs bus words into ASCON rate blocks and queues them for the AEAD core.
//   clk, nRST          : clock, asynchronous active-low reset
//   clear              : synchronous flush of packer, pad state and queue
//   wr_valid/wr_ready  : bus word handshake
//   wr_data            : bus word, first message byte in the MSB
//   wr_last, wr_bytes  : end of message and valid byte count of that word
//   rd_req             : pop the head block
//   rd_valid           : queue non-empty
//   rd_block, rd_len,
//   rd_last            : head block (big-endian), byte count, end of message
//   count              : queued blocks
// A message that ends exactly on a block boundary is followed by a
// zero-length last block (EXTRA_PAD=1) so the core can apply ASCON padding.
// ---------------------------------------------------------------------------
module ascon_blk_fifo
    import ascon_buf_pkg::*;
#(
    parameter int BUS_W     = 32,
    parameter int BLK_W     = 64,
    parameter int DEPTH     = 4,
    parameter int EXTRA_PAD = 1
) (
    input  logic                         clk,
    input  logic                         nRST,
    input  logic                         clear,
    input  logic                         wr_valid,
    input  logic [BUS_W-1:0]             wr_data,
    input  logic                         wr_last,
    input  logic [$clog2(BUS_W/8):0]     wr_bytes,
    output logic                         wr_ready,
    input  logic                         rd_req,
    output logic                         rd_valid,
    output logic [BLK_W-1:0]             rd_block,
    output logic [$clog2(BLK_W/8):0]     rd_len,
    output logic                         rd_last,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int C_WPB   = BLK_W / BUS_W;
    localparam int C_BPW   = BUS_W / 8;
    localparam int C_BPB   = BLK_W / 8;
    localparam int C_IDX_W = (C_WPB > 1) ? $clog2(C_WPB) : 1;
    localparam int C_WB_W  = $clog2(C_BPW) + 1;
    localparam int C_LEN_W = $clog2(C_BPB) + 1;
    localparam int C_CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [BLK_W-1:0]   block;
        logic [C_LEN_W-1:0] len;
        logic               last;
    } entry_t;

    buf_state_t          r_state;
    logic [C_IDX_W-1:0]  r_idx;
    logic [BLK_W-1:0]    r_acc;
    logic [C_LEN_W-1:0]  r_bytes;

    logic                w_accept;
    logic                w_at_end;
    logic                w_complete;
    logic                w_exact;
    logic                w_pad_push;
    logic                w_push;
    logic                w_empty;
    logic                w_full;
    logic [C_WB_W-1:0]   w_nbytes;
    logic [BUS_W-1:0]    w_word;
    logic [BLK_W-1:0]    w_blk;
    logic [C_LEN_W-1:0]  w_len;
    logic [C_CNT_W-1:0]  w_count;
    entry_t              w_entry;
    entry_t              w_head;

    // wr_ready depends only on registered state, never on rd_req.
    assign wr_ready   = (r_state == FILL) && !w_full;
    assign w_accept   = wr_valid && wr_ready;
    assign w_at_end   = (r_idx == C_IDX_W'(C_WPB - 1));
    assign w_complete = w_accept && (wr_last || w_at_end);
    assign w_exact    = (EXTRA_PAD != 0) && wr_last && w_at_end &&
                        (w_nbytes == C_WB_W'(C_BPW));
    assign w_pad_push = (r_state == PAD) && !w_full;
    assign w_push     = w_complete || w_pad_push;
    assign w_len      = r_bytes + C_LEN_W'(w_nbytes);

    // Valid bytes in the current word: full unless last, saturated to the word.
    always_comb begin
        w_nbytes = C_WB_W'(C_BPW);
        if (!wr_last) begin
            w_nbytes = C_WB_W'(C_BPW);
        end else if (wr_bytes > C_WB_W'(C_BPW)) begin
            w_nbytes = C_WB_W'(C_BPW);
        end else begin
            w_nbytes = wr_bytes;
        end
    end

    // Zero the bytes past the valid count, then drop the word into its slot.
    always_comb begin
        w_word = '0;
        w_blk  = r_acc;
        for (int b = 0; b < C_BPW; b++) begin
            w_word[BUS_W-1-8*b -: 8] = (C_WB_W'(b) < w_nbytes) ?
                                       wr_data[BUS_W-1-8*b -: 8] : 8'h00;
        end
        for (int k = 0; k < C_WPB; k++) begin
            w_blk[BLK_W-1-k*BUS_W -: BUS_W] = (r_idx == C_IDX_W'(k)) ?
                                               w_word : r_acc[BLK_W-1-k*BUS_W -: BUS_W];
        end
    end

    // Entry presented to the queue: the pad block or the block being completed.
    always_comb begin
        w_entry = '0;
        if (w_pad_push) begin
            w_entry.block = '0;
            w_entry.len   = C_LEN_W'(0);
            w_entry.last  = 1'b1;
        end else begin
            w_entry.block = w_blk;
            w_entry.len   = w_len;
            w_entry.last  = wr_last && !w_exact;
        end
    end

    // Packer FSM: accumulate words in FILL, emit the pad block in PAD.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state <= FILL;
            r_idx   <= C_IDX_W'(0);
            r_acc   <= '0;
            r_bytes <= C_LEN_W'(0);
        end else if (clear) begin
            r_state <= FILL;
            r_idx   <= C_IDX_W'(0);
            r_acc   <= '0;
            r_bytes <= C_LEN_W'(0);
        end else begin
            case (r_state)
                FILL: begin
                    if (w_complete) begin
                        r_idx   <= C_IDX_W'(0);
                        r_acc   <= '0;
                        r_bytes <= C_LEN_W'(0);
                        r_state <= w_exact ? PAD : FILL;
                    end else if (w_accept) begin
                        r_idx   <= r_idx + C_IDX_W'(1);
                        r_acc   <= w_blk;
                        r_bytes <= w_len;
                        r_state <= FILL;
                    end else begin
                        r_state <= FILL;
                    end
                end
                PAD: begin
                    if (w_pad_push) begin
                        r_state <= FILL;
                    end else begin
                        r_state <= PAD;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    ascon_blk_store #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_store (
        .clk     (clk),
        .nRST    (nRST),
        .clear   (clear),
        .i_push  (w_push),
        .i_data  (w_entry),
        .i_pop   (rd_req),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

    assign rd_valid = !w_empty;
    assign rd_block = w_head.block;
    assign rd_len   = w_head.len;
    assign rd_last  = w_head.last;
    assign count    = w_count;

endmodule

// File: tb/tb_ascon_blk_fifo.sv
module tb_ascon_blk_fifo;

    localparam int EXTRA_PAD = 1;

    logic        clk = 1'b0;
    logic        nRST;
    logic        clear;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_last;
    logic [2:0]  wr_bytes;
    logic        wr_ready;
    logic        rd_req;
    logic        rd_valid;
    logic [63:0] rd_block;
    logic [3:0]  rd_len;
    logic        rd_last;
    logic [2:0]  count;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct { logic [63:0] block; int len; bit last; } exp_t;
    typedef struct { logic [31:0] data; bit last; logic [2:0] bytes; } word_t;
    exp_t  exp_q[$];
    word_t word_q[$];

    ascon_blk_fifo #(.BUS_W(32), .BLK_W(64), .DEPTH(4), .EXTRA_PAD(EXTRA_PAD)) dut (
        .clk(clk), .nRST(nRST), .clear(clear),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last), .wr_bytes(wr_bytes),
        .wr_ready(wr_ready), .rd_req(rd_req), .rd_valid(rd_valid), .rd_block(rd_block),
        .rd_len(rd_len), .rd_last(rd_last), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Offer one word and hold it until accepted; returns just after the accepting edge.
    task automatic send_word(input logic [31:0] d, input bit l, input logic [2:0] b);
        int n;
        n = 0;
        @(negedge clk);
        wr_valid = 1'b1; wr_data = d; wr_last = l; wr_bytes = b;
        while (!wr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!wr_ready) begin
            vectors++; miscompares++;
            $display("FAIL send_word_timeout: wr_ready=%b required 1", wr_ready);
        end
        @(posedge clk);
        #1 wr_valid = 1'b0; wr_last = 1'b0;
    endtask

    task automatic pop_one();
        @(negedge clk);
        rd_req = 1'b1;
        @(posedge clk);
        #1 rd_req = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0; clear = 1'b0; wr_valid = 1'b0; wr_data = 32'h0;
        wr_last = 1'b0; wr_bytes = 3'd0; rd_req = 1'b0;
        #1;
        vectors++;
        if (wr_ready !== 1'b1 || rd_valid !== 1'b0 || count !== 3'd0 ||
            rd_block !== 64'h0 || rd_len !== 4'd0 || rd_last !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: ready=%b valid=%b count=%0d blk=%h len=%0d last=%b required 1 0 0 0 0 0",
                     wr_ready, rd_valid, count, rd_block, rd_len, rd_last);
        end
        repeat (2) @(negedge clk);
        nRST = 1'b1;
        send_word(32'hCAFE0001, 1'b0, 3'd0);
        send_word(32'hCAFE0002, 1'b0, 3'd0);
        send_word(32'hBAD0BAD0, 1'b0, 3'd0);
        #2 nRST = 1'b0;
        #1;
        vectors++;
        if (wr_ready !== 1'b1 || rd_valid !== 1'b0 || count !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_async: ready=%b valid=%b count=%0d required 1 0 0", wr_ready, rd_valid, count);
        end
        @(negedge clk);
        nRST = 1'b1;
        send_word(32'h11111111, 1'b0, 3'd0);
        send_word(32'h22222222, 1'b0, 3'd0);
        @(negedge clk);
        vectors++;
        if (rd_block !== 64'h1111111122222222 || rd_len !== 4'd8 || count !== 3'd1) begin
            miscompares++;
            $display("FAIL reset_discard: blk=%h len=%0d count=%0d required 1111111122222222 8 1", rd_block, rd_len, count);
        end
        pop_one();
    endtask

    task automatic test_full_block();
        send_word(32'h00112233, 1'b0, 3'd0);
        send_word(32'h44556677, 1'b0, 3'd0);
        @(negedge clk);
        vectors++;
        if (rd_valid !== 1'b1 || rd_block !== 64'h0011223344556677 || rd_len !== 4'd8 || rd_last !== 1'b0) begin
            miscompares++;
            $display("FAIL full_block: valid=%b blk=%h len=%0d last=%b required 1 0011223344556677 8 0",
                     rd_valid, rd_block, rd_len, rd_last);
        end
        pop_one();
    endtask

    task automatic test_partial();
        send_word(32'hAABBCCDD, 1'b1, 3'd3);
        @(negedge clk);
        vectors++;
        if (rd_valid !== 1'b1 || rd_block !== 64'hAABBCC0000000000 || rd_len !== 4'd3 || rd_last !== 1'b1) begin
            miscompares++;
            $display("FAIL partial: valid=%b blk=%h len=%0d last=%b required 1 aabbcc0000000000 3 1",
                     rd_valid, rd_block, rd_len, rd_last);
        end
        pop_one();
        send_word(32'h12345678, 1'b0, 3'd0);
        send_word(32'h9ABCDEF0, 1'b1, 3'd0);
        @(negedge clk);
        vectors++;
        if (rd_block !== 64'h1234567800000000 || rd_len !== 4'd4 || rd_last !== 1'b1) begin
            miscompares++;
            $display("FAIL last_zero_bytes_idx1: blk=%h len=%0d last=%b required 1234567800000000 4 1",
                     rd_block, rd_len, rd_last);
        end
        pop_one();
    endtask

    task automatic test_exact_boundary();
        send_word(32'h01020304, 1'b0, 3'd0);
        send_word(32'h05060708, 1'b1, 3'd4);
        @(negedge clk);
        vectors++;
        if (wr_ready !== 1'b0 || count !== 3'd1) begin
            miscompares++;
            $display("FAIL exact_pad_stall: ready=%b count=%0d required 0 1", wr_ready, count);
        end
        @(negedge clk);
        vectors++;
        if (wr_ready !== 1'b1 || count !== 3'd2) begin
            miscompares++;
            $display("FAIL exact_pad_done: ready=%b count=%0d required 1 2", wr_ready, count);
        end
        vectors++;
        if (rd_block !== 64'h0102030405060708 || rd_len !== 4'd8 || rd_last !== 1'b0) begin
            miscompares++;
            $display("FAIL exact_entry0: blk=%h len=%0d last=%b required 0102030405060708 8 0", rd_block, rd_len, rd_last);
        end
        pop_one();
        @(negedge clk);
        vectors++;
        if (rd_valid !== 1'b1 || rd_block !== 64'h0 || rd_len !== 4'd0 || rd_last !== 1'b1) begin
            miscompares++;
            $display("FAIL exact_entry1: valid=%b blk=%h len=%0d last=%b required 1 0 0 1", rd_valid, rd_block, rd_len, rd_last);
        end
        pop_one();
    endtask

    task automatic test_full_queue();
        logic [31:0] w[8];
        logic [31:0] a, b;
        for (int i = 0; i < 8; i++) begin
            w[i] = $urandom;
            send_word(w[i], 1'b0, 3'd0);
        end
        a = $urandom; b = $urandom;
        @(negedge clk);
        vectors++;
        if (count !== 3'd4 || wr_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_count: count=%0d ready=%b required 4 0", count, wr_ready);
        end
        wr_valid = 1'b1; wr_data = a; wr_last = 1'b0;
        @(negedge clk);
        vectors++;
        if (count !== 3'd4 || rd_block !== {w[0], w[1]}) begin
            miscompares++;
            $display("FAIL full_offer_blocked: count=%0d blk=%h required 4 %h", count, rd_block, {w[0], w[1]});
        end
        rd_req = 1'b1;
        @(posedge clk);
        #1 rd_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (count !== 3'd3 || wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL full_after_pop: count=%0d ready=%b required 3 1", count, wr_ready);
        end
        @(posedge clk);
        #1 wr_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (rd_block !== {w[2*i], w[2*i+1]}) begin
                miscompares++;
                $display("FAIL full_order%0d: blk=%h required %h", i, rd_block, {w[2*i], w[2*i+1]});
            end
            rd_req = 1'b1;
            @(posedge clk);
            #1 rd_req = 1'b0;
        end
        send_word(b, 1'b0, 3'd0);
        @(negedge clk);
        vectors++;
        if (rd_block !== {a, b} || count !== 3'd1) begin
            miscompares++;
            $display("FAIL full_resume: blk=%h count=%0d required %h 1", rd_block, count, {a, b});
        end
        pop_one();
    endtask

    task automatic test_empty_and_clear();
        send_word(32'hFFFFFFFF, 1'b1, 3'd0);
        @(negedge clk);
        vectors++;
        if (rd_valid !== 1'b1 || rd_block !== 64'h0 || rd_len !== 4'd0 || rd_last !== 1'b1) begin
            miscompares++;
            $display("FAIL empty_msg: valid=%b blk=%h len=%0d last=%b required 1 0 0 1", rd_valid, rd_block, rd_len, rd_last);
        end
        pop_one();
        send_word(32'hA1A1A1A1, 1'b0, 3'd0);
        send_word(32'hA2A2A2A2, 1'b0, 3'd0);
        send_word(32'hA3A3A3A3, 1'b0, 3'd0);
        @(negedge clk);
        clear = 1'b1; wr_valid = 1'b1; wr_data = 32'hDEADBEEF; rd_req = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0; wr_valid = 1'b0; rd_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (count !== 3'd0 || rd_valid !== 1'b0 || wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_state: count=%0d valid=%b ready=%b required 0 0 1", count, rd_valid, wr_ready);
        end
        send_word(32'hB1B2B3B4, 1'b0, 3'd0);
        send_word(32'hC1C2C3C4, 1'b0, 3'd0);
        @(negedge clk);
        vectors++;
        if (rd_block !== 64'hB1B2B3B4C1C2C3C4 || rd_len !== 4'd8 || count !== 3'd1) begin
            miscompares++;
            $display("FAIL clear_realign: blk=%h len=%0d count=%0d required b1b2b3b4c1c2c3c4 8 1", rd_block, rd_len, count);
        end
        pop_one();
    endtask

    // Random messages; expected blocks come from chunking each message into 8-byte pieces.
    task automatic test_random();
        int cyc, wi;
        exp_t e;
        for (int m = 0; m < 40; m++) begin
            logic [7:0] msg[$];
            int n, nw, vb;
            bit trailing, tail_pad;
            logic [63:0] blk;
            logic [31:0] d;
            logic [2:0] b;
            msg.delete();
            n = $urandom_range(0, 20);
            for (int j = 0; j < n; j++) msg.push_back(8'($urandom));
            trailing = (n > 0) && (n % 4 == 0) && ($urandom_range(0, 1) == 1);
            tail_pad = (n > 0) && (n % 8 == 0) && (trailing || EXTRA_PAD != 0);
            if (n == 0) begin
                exp_q.push_back('{64'h0, 0, 1'b1});
            end else begin
                for (int s = 0; s < n; s += 8) begin
                    int len;
                    len = (n - s < 8) ? n - s : 8;
                    blk = 64'h0;
                    for (int j = 0; j < len; j++) blk[63-8*j -: 8] = msg[s+j];
                    exp_q.push_back('{blk, len, (s + 8 >= n) && !tail_pad});
                end
                if (tail_pad) exp_q.push_back('{64'h0, 0, 1'b1});
            end
            nw = (n == 0) ? 1 : (n + 3) / 4;
            for (int w = 0; w < nw; w++) begin
                d = $urandom;
                vb = n - 4 * w;
                if (vb > 4) vb = 4;
                if (vb < 0) vb = 0;
                for (int j = 0; j < vb; j++) d[31-8*j -: 8] = msg[4*w+j];
                b = 3'($urandom);
                if (w == nw - 1 && !trailing) b = (vb == 4) ? 3'(4 + $urandom_range(0, 3)) : 3'(vb);
                word_q.push_back('{d, (w == nw - 1) && !trailing, b});
            end
            if (trailing) word_q.push_back('{32'($urandom), 1'b1, 3'd0});
        end
        cyc = 0; wi = 0;
        while ((wi < word_q.size() || exp_q.size() > 0) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            wr_valid = (wi < word_q.size()) && ($urandom_range(0, 3) != 0);
            if (wi < word_q.size()) begin
                wr_data = word_q[wi].data; wr_last = word_q[wi].last; wr_bytes = word_q[wi].bytes;
            end
            rd_req = ($urandom_range(0, 1) == 1) || (wi >= word_q.size());
            vectors++;
            if (rd_valid !== (count != 3'd0) || count > 3'd4) begin
                miscompares++;
                $display("FAIL rand_count: valid=%b count=%0d", rd_valid, count);
            end
            if (!rd_valid) begin
                vectors++;
                if (rd_block !== 64'h0 || rd_len !== 4'd0 || rd_last !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rand_idle_zero: blk=%h len=%0d last=%b required 0 0 0", rd_block, rd_len, rd_last);
                end
            end else if (rd_req) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rand_extra_block: blk=%h len=%0d last=%b required none", rd_block, rd_len, rd_last);
                end else begin
                    e = exp_q.pop_front();
                    if (rd_block !== e.block || rd_len !== 4'(e.len) || rd_last !== e.last) begin
                        miscompares++;
                        $display("FAIL rand_block: blk=%h len=%0d last=%b required %h %0d %b",
                                 rd_block, rd_len, rd_last, e.block, e.len, e.last);
                    end
                end
            end
            if (wr_valid && wr_ready) wi++;
        end
        @(negedge clk);
        wr_valid = 1'b0; rd_req = 1'b0; wr_last = 1'b0;
        vectors++;
        if (cyc >= 4000 || exp_q.size() != 0 || wi != word_q.size()) begin
            miscompares++;
            $display("FAIL rand_timeout: cycles=%0d pending_blocks=%0d words_left=%0d required 0 0",
                     cyc, exp_q.size(), word_q.size() - wi);
        end
        @(negedge clk);
        vectors++;
        if (rd_valid !== 1'b0 || count !== 3'd0) begin
            miscompares++;
            $display("FAIL rand_drained: valid=%b count=%0d required 0 0", rd_valid, count);
        end
    endtask

    initial begin
        test_reset();
        test_full_block();
        test_partial();
        test_exact_boundary();
        test_full_queue();
        test_empty_and_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
